// File: rtl/ghost_move_scheduler.sv
// ghost_move_scheduler
// Per-frame movement sequencer for NUM_GHOSTS ghosts sharing one coordinate
// register port. Each ghost in turn is read, given a direction by the AI,
// has its target tile checked against the map, and is written back if the
// target is open.
// Optional feature macro: GHOST_TUNNEL_WRAP_EN
//   defined   -> edge moves wrap to the opposite side and are map-checked
//   undefined -> edge moves are blocked (no map read, no write)
module ghost_move_scheduler #(
    parameter int NUM_GHOSTS  = 4,
    parameter int GRID_W      = 21,
    parameter int GRID_H      = 21,
    parameter int DIR_TIMEOUT = 255
) (
    input  logic       clock_50,
    input  logic       reset_n,
    input  logic       tick,
    output logic       busy,
    output logic       done,
    output logic [2:0] ghost_sel,
    output logic       reg_en,
    output logic       reg_readwrite,
    input  logic [4:0] reg_x_rd,
    input  logic [4:0] reg_y_rd,
    output logic [4:0] reg_x_wr,
    output logic [4:0] reg_y_wr,
    output logic       dir_req,
    input  logic       dir_ack,
    input  logic [1:0] dir,
    output logic       map_rd,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    input  logic       map_wall
);

    localparam int TW = (DIR_TIMEOUT > 1) ? $clog2(DIR_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(DIR_TIMEOUT - 1);
    localparam logic [4:0]    X_MAX      = 5'(GRID_W - 1);
    localparam logic [4:0]    Y_MAX      = 5'(GRID_H - 1);
    localparam logic [2:0]    LAST_GHOST = 3'(NUM_GHOSTS - 1);
`ifdef GHOST_TUNNEL_WRAP_EN
    localparam logic EDGE_BLOCK = 1'b0;
`else
    localparam logic EDGE_BLOCK = 1'b1;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_DIR      = 3'd2,
        S_CALC     = 3'd3,
        S_MAP      = 3'd4,
        S_MAP_WAIT = 3'd5,
        S_WRITE    = 3'd6,
        S_NEXT     = 3'd7
    } state_t;

    state_t          state_q;
    logic [2:0]      ghost_sel_q;
    logic [4:0]      cur_x_q, cur_y_q;
    logic [1:0]      dir_q;
    logic [TW-1:0]   timer_q;
    logic            busy_q, done_q, reg_en_q, reg_rw_q, dir_req_q, map_rd_q;
    logic [4:0]      reg_x_wr_q, reg_y_wr_q, map_x_q, map_y_q;

    logic [4:0]      tgt_x_d, tgt_y_d;
    logic            blocked_d;

    // Target tile for the latched coordinates and direction; edge moves wrap or block
    always_comb begin
        tgt_x_d   = cur_x_q;
        tgt_y_d   = cur_y_q;
        blocked_d = 1'b0;
        case (dir_q)
            2'b00: begin
                if (cur_y_q == 5'd0) begin
                    tgt_y_d   = Y_MAX;
                    blocked_d = EDGE_BLOCK;
                end else begin
                    tgt_y_d   = cur_y_q - 5'd1;
                end
            end
            2'b01: begin
                if (cur_y_q >= Y_MAX) begin
                    tgt_y_d   = 5'd0;
                    blocked_d = EDGE_BLOCK;
                end else begin
                    tgt_y_d   = cur_y_q + 5'd1;
                end
            end
            2'b10: begin
                if (cur_x_q == 5'd0) begin
                    tgt_x_d   = X_MAX;
                    blocked_d = EDGE_BLOCK;
                end else begin
                    tgt_x_d   = cur_x_q - 5'd1;
                end
            end
            2'b11: begin
                if (cur_x_q >= X_MAX) begin
                    tgt_x_d   = 5'd0;
                    blocked_d = EDGE_BLOCK;
                end else begin
                    tgt_x_d   = cur_x_q + 5'd1;
                end
            end
            default: begin
                blocked_d = 1'b1;
            end
        endcase
    end

    // Movement FSM; every output is a register set on entry to the state that owns it
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ghost_sel_q <= 3'd0;
            cur_x_q     <= 5'd0;
            cur_y_q     <= 5'd0;
            dir_q       <= 2'd0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reg_en_q    <= 1'b0;
            reg_rw_q    <= 1'b1;
            dir_req_q   <= 1'b0;
            map_rd_q    <= 1'b0;
            reg_x_wr_q  <= 5'd0;
            reg_y_wr_q  <= 5'd0;
            map_x_q     <= 5'd0;
            map_y_q     <= 5'd0;
        end else begin
            // single-cycle strobes fall back to idle levels unless re-armed below
            reg_en_q  <= 1'b0;
            reg_rw_q  <= 1'b1;
            map_rd_q  <= 1'b0;
            done_q    <= 1'b0;
            dir_req_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        state_q     <= S_READ;
                        busy_q      <= 1'b1;
                        ghost_sel_q <= 3'd0;
                        reg_en_q    <= 1'b1;
                    end else begin
                        state_q     <= S_IDLE;
                    end
                end
                S_READ: begin
                    cur_x_q   <= reg_x_rd;
                    cur_y_q   <= reg_y_rd;
                    timer_q   <= '0;
                    dir_req_q <= 1'b1;
                    state_q   <= S_DIR;
                end
                S_DIR: begin
                    if (dir_ack) begin
                        dir_q   <= dir;
                        state_q <= S_CALC;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q <= S_NEXT;
                        done_q  <= (ghost_sel_q == LAST_GHOST);
                    end else begin
                        timer_q   <= timer_q + TW'(1);
                        dir_req_q <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (blocked_d) begin
                        state_q <= S_NEXT;
                        done_q  <= (ghost_sel_q == LAST_GHOST);
                    end else begin
                        map_x_q  <= tgt_x_d;
                        map_y_q  <= tgt_y_d;
                        map_rd_q <= 1'b1;
                        state_q  <= S_MAP;
                    end
                end
                S_MAP: begin
                    state_q <= S_MAP_WAIT;
                end
                S_MAP_WAIT: begin
                    if (map_wall) begin
                        state_q <= S_NEXT;
                        done_q  <= (ghost_sel_q == LAST_GHOST);
                    end else begin
                        reg_en_q   <= 1'b1;
                        reg_rw_q   <= 1'b0;
                        reg_x_wr_q <= map_x_q;
                        reg_y_wr_q <= map_y_q;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    state_q <= S_NEXT;
                    done_q  <= (ghost_sel_q == LAST_GHOST);
                end
                S_NEXT: begin
                    if (ghost_sel_q == LAST_GHOST) begin
                        busy_q      <= 1'b0;
                        ghost_sel_q <= 3'd0;
                        state_q     <= S_IDLE;
                    end else begin
                        ghost_sel_q <= ghost_sel_q + 3'd1;
                        reg_en_q    <= 1'b1;
                        state_q     <= S_READ;
                    end
                end
                default: begin
                    busy_q      <= 1'b0;
                    ghost_sel_q <= 3'd0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign ghost_sel     = ghost_sel_q;
    assign reg_en        = reg_en_q;
    assign reg_readwrite = reg_rw_q;
    assign reg_x_wr      = reg_x_wr_q;
    assign reg_y_wr      = reg_y_wr_q;
    assign dir_req       = dir_req_q;
    assign map_rd        = map_rd_q;
    assign map_x         = map_x_q;
    assign map_y         = map_y_q;

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Scoreboard bench for ghost_move_scheduler: expected register writes and
// map reads are queued when a pass is set up and popped as the DUT issues them.
module tb_ghost_move_scheduler;

    logic       clock_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       tick     = 1'b0;
    logic       busy, done, reg_en, reg_readwrite, dir_req, map_rd;
    logic [2:0] ghost_sel;
    logic [4:0] reg_x_rd, reg_y_rd, reg_x_wr, reg_y_wr, map_x, map_y;
    logic       dir_ack  = 1'b0;
    logic [1:0] dir      = 2'd0;
    logic       map_wall = 1'b0;

    ghost_move_scheduler dut (
        .clock_50(clock_50), .reset_n(reset_n), .tick(tick),
        .busy(busy), .done(done), .ghost_sel(ghost_sel),
        .reg_en(reg_en), .reg_readwrite(reg_readwrite),
        .reg_x_rd(reg_x_rd), .reg_y_rd(reg_y_rd),
        .reg_x_wr(reg_x_wr), .reg_y_wr(reg_y_wr),
        .dir_req(dir_req), .dir_ack(dir_ack), .dir(dir),
        .map_rd(map_rd), .map_x(map_x), .map_y(map_y), .map_wall(map_wall)
    );

    always #5 clock_50 = ~clock_50;

    // ghost register file, AI table and map model
    logic [4:0]  gx [8];
    logic [4:0]  gy [8];
    logic [1:0]  dir_tab [8];
    int          ack_dly [8];
    logic [4:0]  wall_x = 5'd31, wall_y = 5'd31;
    logic        map_pend = 1'b0;
    int          req_cnt = 0;

    assign reg_x_rd = gx[ghost_sel];
    assign reg_y_rd = gy[ghost_sel];

    logic [12:0] wq [$];
    logic [9:0]  mq [$];
    logic [12:0] w_exp;
    logic [9:0]  m_exp;

    int errors = 0, checks = 0;
    int cyc = 0, tick_cyc = 0, done_cyc = 0, done_cnt = 0;
    int run = 0, to_len = 0;
    logic [2:0] run_sel = 3'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clock_50) cyc++;

    // AI responder: acks ack_dly cycles after dir_req rises (negative = never)
    always @(negedge clock_50) begin
        if (reset_n && dir_req) begin
            dir_ack = (ack_dly[ghost_sel] >= 0) && (req_cnt == ack_dly[ghost_sel]);
            dir     = dir_tab[ghost_sel];
            req_cnt++;
        end else begin
            dir_ack = 1'b0;
            req_cnt = 0;
        end
    end

    // map memory: wall answer appears one cycle after the read strobe
    always @(negedge clock_50) begin
        if (!reset_n) begin
            map_wall = 1'b0;
            map_pend = 1'b0;
        end else begin
            map_wall = map_pend;
            map_pend = map_rd && (map_x == wall_x) && (map_y == wall_y);
        end
    end

    // monitor: scoreboard writes/map reads, done pulses, dir_req run lengths
    always @(negedge clock_50) begin
        if (reset_n) begin
            if (reg_en && !reg_readwrite) begin
                if (wq.size() > 0) begin
                    w_exp = wq.pop_front();
                    check("write", {19'd0, ghost_sel, reg_x_wr, reg_y_wr}, {19'd0, w_exp});
                end else begin
                    check("unexpected_write", {19'd0, ghost_sel, reg_x_wr, reg_y_wr}, 32'hFFFF_FFFF);
                end
                gx[ghost_sel] = reg_x_wr;
                gy[ghost_sel] = reg_y_wr;
            end
            if (map_rd) begin
                if (mq.size() > 0) begin
                    m_exp = mq.pop_front();
                    check("map_rd", {22'd0, map_x, map_y}, {22'd0, m_exp});
                end else begin
                    check("unexpected_map_rd", {22'd0, map_x, map_y}, 32'hFFFF_FFFF);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (dir_req) begin
                run++;
                run_sel = ghost_sel;
            end else if (run != 0) begin
                if (ack_dly[run_sel] < 0) to_len = run;
                run = 0;
            end
        end else begin
            run = 0;
        end
    end

    task automatic setup(input int g, input int x, input int y, input int d, input int dly);
        gx[g]      = 5'(x);
        gy[g]      = 5'(y);
        dir_tab[g] = 2'(d);
        ack_dly[g] = dly;
    endtask

    task automatic exp_move(input int g, input int x, input int y, input bit wr);
        mq.push_back({5'(x), 5'(y)});
        if (wr) wq.push_back({3'(g), 5'(x), 5'(y)});
    endtask

    task automatic pulse_tick();
        @(negedge clock_50);
        tick     = 1'b1;
        tick_cyc = cyc;
        @(negedge clock_50);
        tick     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clock_50);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != start), 32'd1);
    endtask

    task automatic queues_empty(input string tag);
        check({tag, "_wq_left"}, 32'(wq.size()), 32'd0);
        check({tag, "_mq_left"}, 32'(mq.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_done"},    32'(done), 32'd0);
        check({tag, "_sel"},     32'(ghost_sel), 32'd0);
        check({tag, "_reg_en"},  32'(reg_en), 32'd0);
        check({tag, "_rw"},      32'(reg_readwrite), 32'd1);
        check({tag, "_dir_req"}, 32'(dir_req), 32'd0);
        check({tag, "_map_rd"},  32'(map_rd), 32'd0);
        check({tag, "_wr_xy"},   32'({reg_x_wr, reg_y_wr}), 32'd0);
        check({tag, "_map_xy"},  32'({map_x, map_y}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int exp_lat;
        bit found;
        for (int g = 0; g < 8; g++) setup(g, 0, 0, 0, 0);

        // reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clock_50);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clock_50);

        // 1: all ghosts move right, zero-wait ack, open map, 28-cycle pass
        for (int g = 0; g < 4; g++) begin
            setup(g, 2, 2, 3, 0);
            exp_move(g, 3, 2, 1'b1);
        end
        pulse_tick();
        check("t1_busy_on", 32'(busy), 32'd1);
        wait_done("t1", 400);
        check("t1_latency", 32'(done_cyc - tick_cyc), 32'd28);
        @(negedge clock_50);
        check("t1_busy_off", 32'(busy), 32'd0);
        queues_empty("t1");

        // 2: ghost 1 blocked by a wall; mixed directions and ack delays
        setup(0, 2, 2, 3, 0);   exp_move(0, 3, 2, 1'b1);
        setup(1, 5, 5, 0, 0);   exp_move(1, 5, 4, 1'b0);
        setup(2, 8, 8, 1, 1);   exp_move(2, 8, 9, 1'b1);
        setup(3, 10, 10, 2, 3); exp_move(3, 9, 10, 1'b1);
        wall_x = 5'd5;
        wall_y = 5'd4;
        pulse_tick();
        wait_done("t2", 400);
        queues_empty("t2");
        check("t2_g1_unmoved", 32'({gx[1], gy[1]}), 32'({5'd5, 5'd5}));
        wall_x = 5'd31;
        wall_y = 5'd31;

        // 3: every ghost on a grid edge moving outward
        setup(0, 0, 7, 2, 0);
        setup(1, 20, 3, 3, 0);
        setup(2, 4, 0, 0, 0);
        setup(3, 6, 20, 1, 0);
`ifdef GHOST_TUNNEL_WRAP_EN
        exp_move(0, 20, 7, 1'b1);
        exp_move(1, 0, 3, 1'b1);
        exp_move(2, 4, 20, 1'b1);
        exp_move(3, 6, 0, 1'b1);
        exp_lat = 28;
`else
        exp_lat = 16;
`endif
        pulse_tick();
        wait_done("t3", 400);
        check("t3_latency", 32'(done_cyc - tick_cyc), 32'(exp_lat));
        queues_empty("t3");

        // 4: AI never answers ghost 2; ghost 3 still serviced
        for (int g = 0; g < 4; g++) setup(g, 2, 2, 3, 0);
        ack_dly[2] = -1;
        exp_move(0, 3, 2, 1'b1);
        exp_move(1, 3, 2, 1'b1);
        exp_move(3, 3, 2, 1'b1);
        to_len = 0;
        pulse_tick();
        wait_done("t4", 800);
        check("t4_timeout_len", 32'(to_len), 32'd255);
        queues_empty("t4");
        ack_dly[2] = 0;

        // 5: second tick while busy is dropped
        for (int g = 0; g < 4; g++) begin
            setup(g, 10, 10, 1, 0);
            exp_move(g, 10, 11, 1'b1);
        end
        d0 = done_cnt;
        pulse_tick();
        repeat (5) @(negedge clock_50);
        pulse_tick();
        wait_done("t5", 400);
        repeat (60) @(negedge clock_50);
        check("t5_done_count", 32'(done_cnt - d0), 32'd1);
        queues_empty("t5");

        // 6: reset during ghost 1 MAP_WAIT aborts the pending write
        for (int g = 0; g < 4; g++) setup(g, 2, 2, 3, 0);
        exp_move(0, 3, 2, 1'b1);
        exp_move(1, 3, 2, 1'b0);
        pulse_tick();
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clock_50);
            if (map_rd && ghost_sel == 3'd1) found = 1'b1;
        end
        check("t6_map1_seen", 32'(found), 32'd1);
        @(negedge clock_50);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (3) @(negedge clock_50);
        reset_n = 1'b1;
        @(negedge clock_50);
        check("t6_no_partial_write", 32'({gx[1], gy[1]}), 32'({5'd2, 5'd2}));
        queues_empty("t6_abort");
        exp_move(0, 4, 2, 1'b1);
        for (int g = 1; g < 4; g++) exp_move(g, 3, 2, 1'b1);
        pulse_tick();
        wait_done("t6", 400);
        check("t6_latency", 32'(done_cyc - tick_cyc), 32'd28);
        queues_empty("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
